pipe_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards between ID and EX.
- Squashes wrong-path instructions on taken branches and jumps resolved in EX.
- Freezes the pipeline while data memory holds off a request.
- Drives the enable/flush inputs of the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 35 +++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: RV32I opcodes, FSM state
// encodings, NOP instruction word and opcode register-usage helpers.
package pipe_hazard_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] I_TYPE = OPC_OP_IMM;
    localparam logic [6:0] S_TYPE = OPC_STORE;
    localparam logic [6:0] B_TYPE = OPC_BRANCH;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10
    } state_e;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in EX.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [6:0] id_opcode_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic [6:0] ex_opcode_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_valid_i,
    output logic       hazard_o
);

    logic rs1_hit;
    logic rs2_hit;
    logic ex_is_load;

    assign rs1_hit    = uses_rs1(id_opcode_i) && (id_rs1_i == ex_rd_i);
    assign rs2_hit    = uses_rs2(id_opcode_i) && (id_rs2_i == ex_rd_i);
    assign ex_is_load = ex_valid_i && (ex_opcode_i == OPC_LOAD) && (ex_rd_i != '0);
    assign hazard_o   = ex_is_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (load-use, redirect, dmem wait).
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FETCH_LAT = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [6:0]       id_opcode_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [6:0]       ex_opcode_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_valid_i,
    input  logic             ex_redirect_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_stall_o,
    output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_lu_cnt_o,
    output logic [CNT_W-1:0] perf_flush_cnt_o,
    output logic [CNT_W-1:0] perf_mem_cnt_o
`endif
);

    localparam logic [1:0] RELOAD = 2'(FETCH_LAT);

    if ((FETCH_LAT > 3) || (CNT_W == 0)) begin : g_bad_param
        $error("pipe_hazard_ctrl: FETCH_LAT must be 0..3 and CNT_W nonzero");
    end

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       lu_hazard;
    logic       mem_hold;

    load_use_detect u_load_use_detect (
        .id_opcode_i (id_opcode_i),
        .id_rs1_i    (id_rs1_i),
        .id_rs2_i    (id_rs2_i),
        .ex_opcode_i (ex_opcode_i),
        .ex_rd_i     (ex_rd_i),
        .ex_valid_i  (ex_valid_i),
        .hazard_o    (lu_hazard)
    );

    assign mem_hold = dmem_req_i && !dmem_ready_i;
    assign state_o  = state_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The redirect counter is frozen across MEM_WAIT so an interrupted flush resumes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_hold) begin
                    state_d = ST_MEM_WAIT;
                end else if (ex_redirect_i && (FETCH_LAT > 0)) begin
                    cnt_d   = RELOAD;
                    state_d = ST_FLUSH;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready_i) begin
                    state_d = (cnt_q != '0) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (mem_hold) begin
                    state_d = ST_MEM_WAIT;
                end else if (ex_redirect_i) begin
                    cnt_d = RELOAD;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        ex_mem_stall_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_hold) begin
                    pc_stall_o     = 1'b1;
                    if_id_stall_o  = 1'b1;
                    ex_mem_stall_o = 1'b1;
                end else if (ex_redirect_i) begin
                    if_id_flush_o  = 1'b1;
                    id_ex_bubble_o = 1'b1;
                end else if (lu_hazard) begin
                    pc_stall_o     = 1'b1;
                    if_id_stall_o  = 1'b1;
                    id_ex_bubble_o = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!dmem_ready_i) begin
                    pc_stall_o     = 1'b1;
                    if_id_stall_o  = 1'b1;
                    ex_mem_stall_o = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (mem_hold) begin
                    pc_stall_o     = 1'b1;
                    if_id_stall_o  = 1'b1;
                    ex_mem_stall_o = 1'b1;
                end else begin
                    if_id_flush_o  = 1'b1;
                    id_ex_bubble_o = ex_redirect_i;
                end
            end
            default: begin
                pc_stall_o = 1'b0;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic             lu_stall;
    logic [CNT_W-1:0] lu_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] mem_cnt_q;

    assign lu_stall = (state_q == ST_RUN) && !mem_hold && !ex_redirect_i && lu_hazard;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lu_cnt_q    <= '0;
            flush_cnt_q <= '0;
            mem_cnt_q   <= '0;
        end else begin
            if (lu_stall && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            end
            if (if_id_flush_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (ex_mem_stall_o && (mem_cnt_q != '1)) begin
                mem_cnt_q <= mem_cnt_q + CNT_W'(1);
            end
        end
    end

    assign perf_lu_cnt_o    = lu_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
    assign perf_mem_cnt_o   = mem_cnt_q;
`endif

endmodule
